video_layer_regs: RTL and testbench

- Parametrised successor to the fixed-strobe video port latch.
- Holds per-layer scroll offsets, graphics pages and control for N_LAYERS tile/bitmap layers behind one addressed write bus, not one strobe per register.
- Shadow registers are written from the Z80 port decoder. Active copies are latched at line start or frame start per register class. Optional per-layer hardware auto-scroll steps offsets once per frame.
- Sits between the port decoder and the video fetch/render pipeline.

---
 rtl/video_layer_regs_if.sv | 27 ++
 rtl/video_layer_regs.sv | 183 ++++++++++++++++++
 tb/tb_video_layer_regs.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/video_layer_regs_if.sv
// Register write/readback bus between the Z80 port decoder and the video layer register bank.
// The decoder drives addresses, data and strobe; the bank returns registered readback data.
interface video_layer_regs_if #(
  parameter int ADDR_W = 5
);
  logic [7:0]        d;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  modport master (
    output d,
    output wr_addr,
    output wr_en,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  d,
    input  wr_addr,
    input  wr_en,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/video_layer_regs.sv
// Per-layer scroll/page/control shadow registers with line- and frame-synchronous active copies
// and optional once-per-frame hardware auto-scroll.
module video_layer_regs #(
  parameter int N_LAYERS = 3,
  parameter int OFFS_W   = 9,
  parameter int ADDR_W   = 5
) (
  input  logic                         clk,
  input  logic                         res_n,
  video_layer_regs_if.slave            bus,
  input  logic                         line_start_s,
  input  logic                         frame_start,
  output logic [N_LAYERS*OFFS_W-1:0]   x_offs,
  output logic [N_LAYERS*OFFS_W-1:0]   y_offs,
  output logic [N_LAYERS*8-1:0]        gpage
);

  localparam int LW = ADDR_W - 3;

  typedef logic [OFFS_W-1:0] offs_t;

  offs_t      shx_q   [N_LAYERS];
  offs_t      shx_d   [N_LAYERS];
  offs_t      shy_q   [N_LAYERS];
  offs_t      shy_d   [N_LAYERS];
  logic [7:0] gp_q    [N_LAYERS];
  logic [7:0] gp_d    [N_LAYERS];
  logic [7:0] xstep_q [N_LAYERS];
  logic [7:0] xstep_d [N_LAYERS];
  logic [7:0] ystep_q [N_LAYERS];
  logic [7:0] ystep_d [N_LAYERS];
  logic [7:0] ctrl_q  [N_LAYERS];
  logic [7:0] ctrl_d  [N_LAYERS];
  offs_t      ax_q    [N_LAYERS];
  offs_t      ax_d    [N_LAYERS];
  offs_t      ay_q    [N_LAYERS];
  offs_t      ay_d    [N_LAYERS];
  logic [7:0] ag_q    [N_LAYERS];
  logic [7:0] ag_d    [N_LAYERS];
  logic [7:0] rd_data_q;
  logic [7:0] rd_data_d;

  logic [LW-1:0] wr_layer_s;
  logic [2:0]    wr_reg_s;
  logic [LW-1:0] rd_layer_s;
  logic [2:0]    rd_reg_s;

  // Signed 8-bit step applied modulo 2^OFFS_W.
  function automatic offs_t step_offs(input offs_t cur, input logic [7:0] stp);
    return cur + {{(OFFS_W-8){stp[7]}}, stp};
  endfunction

  // High byte keeps only the bits that fit above bit 7; surplus data bits fall off in the cast.
  function automatic offs_t write_byte(input offs_t cur, input logic hi, input logic [7:0] val);
    offs_t res;
    if (hi) begin
      res = OFFS_W'({val, cur[7:0]});
    end else begin
      res = {cur[OFFS_W-1:8], val};
    end
    return res;
  endfunction

  function automatic logic [7:0] hi_byte(input offs_t v);
    logic [15:0] w;
    w = 16'(v);
    return w[15:8];
  endfunction

  assign wr_layer_s = bus.wr_addr[ADDR_W-1:3];
  assign wr_reg_s   = bus.wr_addr[2:0];
  assign rd_layer_s = bus.rd_addr[ADDR_W-1:3];
  assign rd_reg_s   = bus.rd_addr[2:0];

  // Next-state for shadow, step, ctrl and active registers of every layer.
  always_comb begin : next_state_comb
    logic wr_hit;
    logic step_en;
    wr_hit  = 1'b0;
    step_en = 1'b0;
    for (int l = 0; l < N_LAYERS; l++) begin
      wr_hit  = bus.wr_en && (wr_layer_s == LW'(l));
      step_en = frame_start && ctrl_q[l][0];

      // A write to either byte of an offset cancels that offset's step this frame.
      if (wr_hit && (wr_reg_s[2:1] == 2'b00)) begin
        shx_d[l] = write_byte(shx_q[l], wr_reg_s[0], bus.d);
      end else if (step_en) begin
        shx_d[l] = step_offs(shx_q[l], xstep_q[l]);
      end else begin
        shx_d[l] = shx_q[l];
      end

      if (wr_hit && (wr_reg_s[2:1] == 2'b01)) begin
        shy_d[l] = write_byte(shy_q[l], wr_reg_s[0], bus.d);
      end else if (step_en) begin
        shy_d[l] = step_offs(shy_q[l], ystep_q[l]);
      end else begin
        shy_d[l] = shy_q[l];
      end

      gp_d[l]    = (wr_hit && (wr_reg_s == 3'd4)) ? bus.d : gp_q[l];
      xstep_d[l] = (wr_hit && (wr_reg_s == 3'd5)) ? bus.d : xstep_q[l];
      ystep_d[l] = (wr_hit && (wr_reg_s == 3'd6)) ? bus.d : ystep_q[l];
      ctrl_d[l]  = (wr_hit && (wr_reg_s == 3'd7)) ? bus.d : ctrl_q[l];

      ax_d[l] = line_start_s ? shx_q[l] : ax_q[l];
      ag_d[l] = line_start_s ? gp_q[l]  : ag_q[l];

      // Frame mode takes the post-step value so the new frame renders with it.
      if (!ctrl_q[l][1]) begin
        ay_d[l] = shy_q[l];
      end else if (frame_start) begin
        ay_d[l] = shy_d[l];
      end else begin
        ay_d[l] = ay_q[l];
      end
    end
  end

  // Readback mux over the shadow registers; unmapped layers read as zero.
  always_comb begin : readback_comb
    logic [7:0] val;
    val       = 8'h00;
    rd_data_d = 8'h00;
    for (int l = 0; l < N_LAYERS; l++) begin
      case (rd_reg_s)
        3'd0:    val = shx_q[l][7:0];
        3'd1:    val = hi_byte(shx_q[l]);
        3'd2:    val = shy_q[l][7:0];
        3'd3:    val = hi_byte(shy_q[l]);
        3'd4:    val = gp_q[l];
        3'd5:    val = xstep_q[l];
        3'd6:    val = ystep_q[l];
        3'd7:    val = ctrl_q[l];
        default: val = 8'h00;
      endcase
      rd_data_d = rd_data_d | ((rd_layer_s == LW'(l)) ? val : 8'h00);
    end
  end

  // State registers; asynchronous reset also discards any pending latch.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      shx_q     <= '{default: '0};
      shy_q     <= '{default: '0};
      gp_q      <= '{default: '0};
      xstep_q   <= '{default: '0};
      ystep_q   <= '{default: '0};
      ctrl_q    <= '{default: '0};
      ax_q      <= '{default: '0};
      ay_q      <= '{default: '0};
      ag_q      <= '{default: '0};
      rd_data_q <= 8'h00;
    end else begin
      shx_q     <= shx_d;
      shy_q     <= shy_d;
      gp_q      <= gp_d;
      xstep_q   <= xstep_d;
      ystep_q   <= ystep_d;
      ctrl_q    <= ctrl_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      ag_q      <= ag_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Pack active copies, layer 0 in the LSBs.
  always_comb begin : pack_comb
    x_offs = '0;
    y_offs = '0;
    gpage  = '0;
    for (int l = 0; l < N_LAYERS; l++) begin
      x_offs[l*OFFS_W +: OFFS_W] = ax_q[l];
      y_offs[l*OFFS_W +: OFFS_W] = ay_q[l];
      gpage[l*8 +: 8]            = ag_q[l];
    end
  end

  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_video_layer_regs.sv
// Randomised and directed bench for video_layer_regs against a register-level reference model.
module tb_video_layer_regs;
  localparam int N_LAYERS = 3;
  localparam int OFFS_W   = 9;
  localparam int ADDR_W   = 5;
  localparam int MODV     = 1 << OFFS_W;

  logic clk;
  logic res_n;
  logic line_start_s;
  logic frame_start;
  logic [N_LAYERS*OFFS_W-1:0] x_offs;
  logic [N_LAYERS*OFFS_W-1:0] y_offs;
  logic [N_LAYERS*8-1:0]      gpage;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (plain integers).
  int sx [N_LAYERS];
  int sy [N_LAYERS];
  int gp [N_LAYERS];
  int xs [N_LAYERS];
  int ys [N_LAYERS];
  int ct [N_LAYERS];
  int ax [N_LAYERS];
  int ay [N_LAYERS];
  int ag [N_LAYERS];
  int rd_m;

  video_layer_regs_if #(.ADDR_W(ADDR_W)) bus ();

  video_layer_regs #(
    .N_LAYERS(N_LAYERS),
    .OFFS_W  (OFFS_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk         (clk),
    .res_n       (res_n),
    .bus         (bus),
    .line_start_s(line_start_s),
    .frame_start (frame_start),
    .x_offs      (x_offs),
    .y_offs      (y_offs),
    .gpage       (gpage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sext8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic int wrapm(input int v);
    return ((v % MODV) + MODV) % MODV;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < N_LAYERS; l++) begin
      sx[l] = 0; sy[l] = 0; gp[l] = 0; xs[l] = 0; ys[l] = 0;
      ct[l] = 0; ax[l] = 0; ay[l] = 0; ag[l] = 0;
    end
    rd_m = 0;
  endtask

  // One clock edge of the register bank, from the register-map rules.
  task automatic model_step(input bit we, input int wa, input int wd, input int ra,
                            input bit ls, input bit fs);
    int nsx [N_LAYERS];
    int nsy [N_LAYERS];
    int wl, rg, rl, rr;
    wl = wa / 8; rg = wa % 8; rl = ra / 8; rr = ra % 8;

    rd_m = 0;
    if (rl < N_LAYERS) begin
      case (rr)
        0: rd_m = sx[rl] % 256;
        1: rd_m = sx[rl] / 256;
        2: rd_m = sy[rl] % 256;
        3: rd_m = sy[rl] / 256;
        4: rd_m = gp[rl];
        5: rd_m = xs[rl];
        6: rd_m = ys[rl];
        default: rd_m = ct[rl];
      endcase
    end

    for (int l = 0; l < N_LAYERS; l++) begin
      bit hit, stp;
      hit = we && (wl == l);
      stp = fs && (ct[l] % 2 == 1);
      nsx[l] = sx[l];
      nsy[l] = sy[l];
      if (hit && rg == 0)      nsx[l] = (sx[l] / 256) * 256 + wd;
      else if (hit && rg == 1) nsx[l] = (wd % (1 << (OFFS_W - 8))) * 256 + sx[l] % 256;
      else if (stp)            nsx[l] = wrapm(sx[l] + sext8(xs[l]));
      if (hit && rg == 2)      nsy[l] = (sy[l] / 256) * 256 + wd;
      else if (hit && rg == 3) nsy[l] = (wd % (1 << (OFFS_W - 8))) * 256 + sy[l] % 256;
      else if (stp)            nsy[l] = wrapm(sy[l] + sext8(ys[l]));

      if (ls) begin
        ax[l] = sx[l];
        ag[l] = gp[l];
      end
      if ((ct[l] / 2) % 2 == 0) ay[l] = sy[l];
      else if (fs)              ay[l] = nsy[l];

      sx[l] = nsx[l];
      sy[l] = nsy[l];
      if (hit && rg == 4) gp[l] = wd;
      if (hit && rg == 5) xs[l] = wd;
      if (hit && rg == 6) ys[l] = wd;
      if (hit && rg == 7) ct[l] = wd;
    end
  endtask

  task automatic check_all();
    for (int l = 0; l < N_LAYERS; l++) begin
      check_eq($sformatf("x_offs[%0d]", l), 64'(x_offs[l*OFFS_W +: OFFS_W]), 64'(ax[l]));
      check_eq($sformatf("y_offs[%0d]", l), 64'(y_offs[l*OFFS_W +: OFFS_W]), 64'(ay[l]));
      check_eq($sformatf("gpage[%0d]", l),  64'(gpage[l*8 +: 8]),            64'(ag[l]));
    end
    check_eq("rd_data", 64'(bus.rd_data), 64'(rd_m));
  endtask

  // Check outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic cyc(input bit we, input int wa, input int wd, input int ra,
                     input bit ls, input bit fs);
    @(negedge clk);
    check_all();
    bus.wr_en    = we;
    bus.wr_addr  = ADDR_W'(wa);
    bus.d        = 8'(wd);
    bus.rd_addr  = ADDR_W'(ra);
    line_start_s = ls;
    frame_start  = fs;
    model_step(we, wa, wd, ra, ls, fs);
  endtask

  task automatic idle(input int ra);
    cyc(1'b0, 0, 0, ra, 1'b0, 1'b0);
  endtask

  initial begin
    res_n        = 1'b0;
    line_start_s = 1'b0;
    frame_start  = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.d        = 8'h00;
    bus.rd_addr  = '0;
    model_reset();

    repeat (2) @(negedge clk);
    check_all();
    res_n = 1'b1;
    model_step(1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Layer 1 X offset reaches the active copy only on line start.
    cyc(1'b1, 8, 'h34, 0, 1'b0, 1'b0);
    cyc(1'b1, 9, 'h01, 8, 1'b0, 1'b0);
    cyc(1'b0, 0, 0, 8, 1'b1, 1'b0);
    check_eq("rd_l1_xlo", 64'(bus.rd_data), 64'h34);
    check_eq("x1_before_line", 64'(x_offs[17:9]), 64'h0);
    idle(0);
    check_eq("x1_after_line", 64'(x_offs[17:9]), 64'h134);

    // Layer 0 auto-scroll wraps downward, then steps by +2 twice.
    cyc(1'b1, 7, 'h01, 0, 1'b0, 1'b0);
    cyc(1'b1, 5, 'hFF, 0, 1'b0, 1'b0);
    cyc(1'b1, 0, 'h00, 0, 1'b0, 1'b0);
    cyc(1'b1, 1, 'h00, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
    cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle(0);
    check_eq("x0_wrap", 64'(x_offs[8:0]), 64'h1FF);
    cyc(1'b1, 5, 'h02, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
    cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
    cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle(0);
    check_eq("x0_two_frames", 64'(x_offs[8:0]), 64'h003);

    // Layer 2 Y in frame mode takes the stepped value on the frame edge itself.
    cyc(1'b1, 23, 'h03, 0, 1'b0, 1'b0);
    cyc(1'b1, 22, 'h10, 0, 1'b0, 1'b0);
    cyc(1'b1, 18, 'hF8, 0, 1'b0, 1'b0);
    cyc(1'b1, 19, 'h01, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(0);
    check_eq("y2_frame_step", 64'(y_offs[26:18]), 64'h008);
    cyc(1'b1, 23, 'h01, 0, 1'b0, 1'b0);
    cyc(1'b1, 18, 'h55, 0, 1'b0, 1'b0);
    idle(0);
    idle(0);
    check_eq("y2_immediate", 64'(y_offs[26:18]), 64'h055);

    // Write coincident with frame start cancels the step.
    cyc(1'b1, 0, 'h20, 0, 1'b0, 1'b1);
    idle(0);
    idle(1);
    check_eq("x0_wr_cancels_lo", 64'(bus.rd_data), 64'h20);
    idle(0);
    check_eq("x0_wr_cancels_hi", 64'(bus.rd_data), 64'h00);

    // Out-of-range layer is ignored and reads as zero.
    cyc(1'b1, 24, 'hAB, 24, 1'b1, 1'b0);
    idle(24);
    check_eq("rd_layer3", 64'(bus.rd_data), 64'h00);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset between clock edges.
    @(negedge clk);
    check_all();
    bus.wr_en = 1'b0; line_start_s = 1'b0; frame_start = 1'b0;
    #2 res_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("async_rst_x", 64'(x_offs), 64'h0);
    check_eq("async_rst_y", 64'(y_offs), 64'h0);
    @(negedge clk);
    res_n = 1'b1;
    model_step(1'b0, 0, 0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle(0);
    check_eq("post_rst_x", 64'(x_offs), 64'h0);
    check_eq("post_rst_g", 64'(gpage), 64'h0);
    @(negedge clk);
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
